// File: rtl/sdram_arbiter.sv
// ============================================================================
// sdram_arbiter -- four round-robin read ports plus one buffered download
// write port sharing a single-outstanding-transaction SDRAM controller.
// Revision 1.0
// ============================================================================
`default_nettype none

module sdram_arbiter #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr_0,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  input  logic [ADDR_WIDTH-1:0] rd_addr_2,
  input  logic [ADDR_WIDTH-1:0] rd_addr_3,
  output logic [3:0]            rd_ack,
  output logic [3:0]            rd_valid,
  output logic [DATA_WIDTH-1:0] rd_q,
  input  logic                  dl_download,
  input  logic                  dl_wr,
  input  logic [ADDR_WIDTH-1:0] dl_addr,
  input  logic [DATA_WIDTH-1:0] dl_data,
  output logic                  dl_overrun,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [DATA_WIDTH-1:0] sdram_data,
  output logic                  sdram_we,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  input  logic                  sdram_valid,
  input  logic [DATA_WIDTH-1:0] sdram_q,
  output logic                  busy,
  output logic [2:0]            grant
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ACK   = 2'd1,
    WAIT_VALID = 2'd2
  } state_t;

  localparam logic [2:0] GRANT_DL = 3'd4;

  state_t                  state, state_next;
  logic [1:0]              ptr;
  logic [1:0]              rr_sel, rr_idx;
  logic                    rr_hit;
  logic [ADDR_WIDTH-1:0]   rd_addr_sel;
  logic                    issue_dl, issue_rd;
  logic                    ack_now, wr_ack_now;
  logic                    buf_pending;
  logic [ADDR_WIDTH-1:0]   buf_addr;
  logic [DATA_WIDTH-1:0]   buf_data;
  logic                    dl_download_d;

  // Lowest offset from ptr wins: iterate downwards so it is assigned last.
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = ptr;
    rr_idx = ptr;
    for (int j = 3; j >= 0; j--) begin
      rr_idx = ptr + 2'(j);
      if (rd_req[rr_idx]) begin
        rr_hit = 1'b1;
        rr_sel = rr_idx;
      end
    end
  end

  always_comb begin
    case (rr_sel)
      2'd0:    rd_addr_sel = rd_addr_0;
      2'd1:    rd_addr_sel = rd_addr_1;
      2'd2:    rd_addr_sel = rd_addr_2;
      default: rd_addr_sel = rd_addr_3;
    endcase
  end

  assign ack_now    = (state == WAIT_ACK) && sdram_ack;
  assign wr_ack_now = ack_now && (grant == GRANT_DL);

  always_comb begin
    state_next = state;
    issue_dl   = 1'b0;
    issue_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (buf_pending) begin
          issue_dl   = 1'b1;
          state_next = WAIT_ACK;
        end else if (!dl_download && rr_hit) begin
          issue_rd   = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) state_next = (grant == GRANT_DL) ? IDLE : WAIT_VALID;
      end
      WAIT_VALID: begin
        if (sdram_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Request registers: launched on the grant edge, frozen until the ack edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= 3'd0;
      ptr        <= 2'd0;
      sdram_req  <= 1'b0;
      sdram_we   <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
    end else if (issue_dl) begin
      grant      <= GRANT_DL;
      sdram_req  <= 1'b1;
      sdram_we   <= 1'b1;
      sdram_addr <= buf_addr;
      sdram_data <= buf_data;
    end else if (issue_rd) begin
      grant      <= {1'b0, rr_sel};
      ptr        <= rr_sel + 2'd1;
      sdram_req  <= 1'b1;
      sdram_we   <= 1'b0;
      sdram_addr <= rd_addr_sel;
      sdram_data <= '0;
    end else if (ack_now) begin
      sdram_req  <= 1'b0;
    end
  end

  // Single-entry write buffer; a slot freed by this cycle's ack may be refilled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_pending   <= 1'b0;
      buf_addr      <= '0;
      buf_data      <= '0;
      dl_overrun    <= 1'b0;
      dl_download_d <= 1'b0;
    end else begin
      dl_download_d <= dl_download;
      if (dl_download && !dl_download_d) dl_overrun <= 1'b0;
      if (dl_wr) begin
        if (!buf_pending || wr_ack_now) begin
          buf_pending <= 1'b1;
          buf_addr    <= dl_addr;
          buf_data    <= dl_data;
        end else begin
          dl_overrun  <= 1'b1;
        end
      end else if (wr_ack_now) begin
        buf_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_ack   = 4'd0;
    rd_valid = 4'd0;
    for (int i = 0; i < 4; i++) begin
      rd_ack[i]   = sdram_ack   && (state == WAIT_ACK)   && (grant == 3'(i));
      rd_valid[i] = sdram_valid && (state == WAIT_VALID) && (grant == 3'(i));
    end
  end

  assign rd_q = sdram_q;
  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
// tb_sdram_arbiter -- directed self-checking bench for sdram_arbiter.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sdram_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    rd_req;
  logic [AW-1:0] rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3;
  logic [3:0]    rd_ack, rd_valid;
  logic [DW-1:0] rd_q;
  logic          dl_download, dl_wr;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_data;
  logic          dl_overrun;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_data;
  logic          sdram_we, sdram_req, sdram_ack, sdram_valid;
  logic [DW-1:0] sdram_q;
  logic          busy;
  logic [2:0]    grant;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_addr_2(rd_addr_2), .rd_addr_3(rd_addr_3),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_q(rd_q),
    .dl_download(dl_download), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .dl_data(dl_data), .dl_overrun(dl_overrun),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
    .sdram_q(sdram_q), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete read: grant edge, ack cycle, valid cycle, back to IDLE.
  task automatic do_read(input int port, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic [3:0] onehot;
    onehot = 4'b0001 << port;
    tick();
    chk("rd_req_up",   sdram_req, 1'b1);
    chk("rd_grant",    grant, 3'(port));
    chk("rd_addr",     sdram_addr, addr);
    chk("rd_we",       sdram_we, 1'b0);
    sdram_ack = 1'b1;
    #1;
    chk("rd_ack",      rd_ack, onehot);
    tick();
    sdram_ack = 1'b0;
    rd_req[port] = 1'b0;
    chk("rd_req_down", sdram_req, 1'b0);
    sdram_valid = 1'b1;
    sdram_q     = data;
    #1;
    chk("rd_valid",    rd_valid, onehot);
    chk("rd_q",        rd_q, data);
    tick();
    sdram_valid = 1'b0;
    chk("rd_idle",     busy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; rd_req = 4'd0;
    rd_addr_0 = 23'h000100; rd_addr_1 = 23'h000101;
    rd_addr_2 = 23'h000102; rd_addr_3 = 23'h000103;
    dl_download = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;
    tick(); tick();
    chk("rst_req",   sdram_req, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_grant", grant, 3'd0);
    chk("rst_addr",  sdram_addr, 23'd0);
    chk("rst_data",  sdram_data, 32'd0);
    chk("rst_we",    sdram_we, 1'b0);
    chk("rst_ovr",   dl_overrun, 1'b0);
    chk("rst_ptr",   dut.ptr, 2'd0);
    reset_n = 1'b1;
    tick();

    // Single read with ack 2 cycles and valid 4 cycles after the ack.
    rd_req = 4'b0001; rd_addr_0 = 23'h000123;
    tick();
    chk("s_req",   sdram_req, 1'b1);
    chk("s_addr",  sdram_addr, 23'h000123);
    chk("s_we",    sdram_we, 1'b0);
    chk("s_ack0",  rd_ack, 4'b0000);
    tick();
    sdram_ack = 1'b1;
    #1;
    chk("s_ack",   rd_ack, 4'b0001);
    tick();
    sdram_ack = 1'b0; rd_req = 4'b0000;
    chk("s_reqdn", sdram_req, 1'b0);
    chk("s_busy",  busy, 1'b1);
    tick();
    chk("s_noack", rd_ack, 4'b0000);
    tick();
    chk("s_noval", rd_valid, 4'b0000);
    tick();
    sdram_valid = 1'b1; sdram_q = 32'hDEADBEEF;
    #1;
    chk("s_valid", rd_valid, 4'b0001);
    chk("s_q",     rd_q, 32'hDEADBEEF);
    tick();
    chk("s_idle",  busy, 1'b0);
    chk("s_ptr",   dut.ptr, 2'd1);
    // Stray valid in IDLE yields nothing.
    #1;
    chk("stray_valid", rd_valid, 4'b0000);
    tick();
    sdram_valid = 1'b0;
    rd_addr_0 = 23'h000100;

    // Round robin from ptr 0; port 0 re-requests before port 3 is served.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    rd_req = 4'b1111;
    do_read(0, 23'h000100, 32'hA0A0A0A0);
    do_read(1, 23'h000101, 32'hA1A1A1A1);
    do_read(2, 23'h000102, 32'hA2A2A2A2);
    rd_req = 4'b1001;
    do_read(3, 23'h000103, 32'hA3A3A3A3);
    do_read(0, 23'h000100, 32'hB0B0B0B0);
    chk("rr_ptr", dut.ptr, 2'd1);

    // Download priority: read port 1 blocked while the download is active.
    rd_req = 4'b0010; dl_download = 1'b1;
    dl_wr = 1'b1; dl_addr = 23'h000010; dl_data = 32'h11223344;
    tick();
    dl_wr = 1'b0;
    chk("dl_cap_req", sdram_req, 1'b0);
    tick();
    chk("dl_req",   sdram_req, 1'b1);
    chk("dl_we",    sdram_we, 1'b1);
    chk("dl_addr",  sdram_addr, 23'h000010);
    chk("dl_data",  sdram_data, 32'h11223344);
    chk("dl_grant", grant, 3'd4);
    sdram_ack = 1'b1;
    #1;
    chk("dl_no_rdack", rd_ack, 4'b0000);
    tick();
    sdram_ack = 1'b0;
    chk("dl_done", sdram_req, 1'b0);
    tick();
    chk("dl_block_busy", busy, 1'b0);
    tick();
    chk("dl_block_ack", rd_ack, 4'b0000);
    chk("dl_block_req", sdram_req, 1'b0);
    dl_download = 1'b0;
    do_read(1, 23'h000101, 32'hC1C1C1C1);

    // Overrun: second write arrives while the first waits 5 cycles for ack.
    dl_download = 1'b1;
    dl_wr = 1'b1; dl_addr = 23'h000020; dl_data = 32'hAAAA0001;
    tick();
    dl_wr = 1'b0;
    tick();
    dl_wr = 1'b1; dl_addr = 23'h000021; dl_data = 32'hBBBB0002;
    chk("ov_req",  sdram_req, 1'b1);
    chk("ov_addr", sdram_addr, 23'h000020);
    tick();
    dl_wr = 1'b0;
    chk("ov_flag",   dl_overrun, 1'b1);
    chk("ov_stable", sdram_addr, 23'h000020);
    tick();
    chk("ov_data",   sdram_data, 32'hAAAA0001);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("ov_reqdn", sdram_req, 1'b0);
    tick();
    chk("ov_nosecond", sdram_req, 1'b0);
    chk("ov_sticky",   dl_overrun, 1'b1);
    dl_download = 1'b0;
    tick();
    chk("ov_hold", dl_overrun, 1'b1);
    dl_download = 1'b1;
    tick();
    chk("ov_clear", dl_overrun, 1'b0);

    // A write arriving with the buffered write's ack is captured, no overrun.
    dl_wr = 1'b1; dl_addr = 23'h000030; dl_data = 32'h00000001;
    tick();
    dl_wr = 1'b0;
    tick();
    chk("sa_addr1", sdram_addr, 23'h000030);
    sdram_ack = 1'b1; dl_wr = 1'b1; dl_addr = 23'h000031; dl_data = 32'h00000002;
    tick();
    sdram_ack = 1'b0; dl_wr = 1'b0;
    chk("sa_noovr", dl_overrun, 1'b0);
    tick();
    chk("sa_req2",  sdram_req, 1'b1);
    chk("sa_addr2", sdram_addr, 23'h000031);
    chk("sa_data2", sdram_data, 32'h00000002);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0; dl_download = 1'b0;
    tick();

    // Reset during WAIT_VALID abandons the read.
    rd_req = 4'b0001;
    tick();
    chk("mr_grant", grant, 3'd0);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0; rd_req = 4'b0000;
    chk("mr_busy", busy, 1'b1);
    chk("mr_ptr1", dut.ptr, 2'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_async_busy", busy, 1'b0);
    chk("mr_async_req",  sdram_req, 1'b0);
    chk("mr_async_ptr",  dut.ptr, 2'd0);
    tick();
    reset_n = 1'b1;
    tick();
    sdram_valid = 1'b1; sdram_q = 32'h55555555;
    #1;
    chk("mr_novalid", rd_valid, 4'b0000);
    chk("mr_grant0",  grant, 3'd0);
    chk("mr_addr0",   sdram_addr, 23'd0);
    chk("mr_we0",     sdram_we, 1'b0);
    tick();
    sdram_valid = 1'b0;
    chk("mr_idle", busy, 1'b0);
    rd_req = 4'b1010;
    do_read(1, 23'h000101, 32'hD1D1D1D1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
